// File: rtl/mem_load_pkg.sv
// mem_load_pkg: opcodes, widths and state encoding shared by the load sequencer
package mem_load_pkg;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam logic [2:0] OP_LOAD_I1  = 3'd0;
   localparam logic [2:0] OP_LOAD_I2  = 3'd1;
   localparam logic [2:0] OP_LOAD_D   = 3'd2;
   localparam logic [2:0] OP_RUN      = 3'd3;
   localparam logic [2:0] OP_READBACK = 3'd4;
   typedef enum logic [3:0] {
      S_IDLE, S_LD_SEL, S_LD_WAIT, S_LD_SETUP, S_LD_PULSE, S_LD_HOLD, S_RUN,
      S_RB_ADDR, S_RB_SETUP, S_RB_WAIT, S_RB_OUT, S_RB_HOLD
   } state_t;
   function automatic logic is_load(input logic [2:0] op);
      return op <= OP_LOAD_D;
   endfunction
endpackage

// File: rtl/strobe_timer.sv
// strobe_timer: loadable down-counter; done is high during the last of the loaded cycles
module strobe_timer #(
   parameter int W = 17
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign done = cnt == W'(1);
endmodule

// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer: framed-stream driven IRAM/DRAM load, timed run and DRAM readback for top_control_2
// Optional MEM_LOAD_CHECKSUM_EN adds load_sum, the 16-bit sum of the current/last load payload.
module mem_load_sequencer
   import mem_load_pkg::*;
#(
   parameter int LOAD_BASE  = 1,
   parameter int SETUP_CYC  = 2,
   parameter int PULSE_CYC  = 4,
   parameter int HOLD_CYC   = 4,
   parameter int RD_LAT_CYC = 5,
   parameter int RUN_CYCLES = 120000
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] addr_ext,
   output logic [DATA_W-1:0] Data_in_ins,
   output logic [DATA_W-1:0] Data_in_dram,
   output logic              iram_write_ext_1,
   output logic              iram_write_ext_2,
   output logic              dram_write_ext,
   output logic              read_en_ext,
   input  logic [DATA_W-1:0] dram_in_1,
   output logic              start,
   output logic              start_2,
   output logic              start_3,
   output logic              start_4,
   output logic              busy,
   output logic              err
`ifdef MEM_LOAD_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] load_sum
`endif
);
   localparam int TW = $clog2(RUN_CYCLES + 1);
   state_t            st, nx;
   logic [2:0]        op;
   logic [ADDR_W-1:0] cnt;
   logic              tmr_ld, tmr_done;
   logic [TW-1:0]     tmr_val;
   logic              hs, last, ld_st;
   logic [2:0]        hdr_op;

   assign hdr_op = in_data[15:13];
   assign hs     = in_valid && in_ready;
   assign last   = cnt == ADDR_W'(1);
   assign ld_st  = st inside {S_LD_SEL, S_LD_WAIT, S_LD_SETUP, S_LD_PULSE, S_LD_HOLD};

   // in_ready is gated by reset so every output reads 0 while rst_n is low
   assign in_ready         = rst_n && (st inside {S_IDLE, S_LD_WAIT, S_RB_ADDR});
   assign busy             = st != S_IDLE;
   assign start            = st == S_RUN;
   assign start_2          = ld_st && op != OP_LOAD_D;
   assign start_3          = ld_st && op == OP_LOAD_D;
   assign start_4          = st inside {S_RB_ADDR, S_RB_SETUP, S_RB_WAIT, S_RB_OUT, S_RB_HOLD};
   assign iram_write_ext_1 = st == S_LD_PULSE && op == OP_LOAD_I1;
   assign iram_write_ext_2 = st == S_LD_PULSE && op == OP_LOAD_I2;
   assign dram_write_ext   = st == S_LD_PULSE && op == OP_LOAD_D;
   assign read_en_ext      = st inside {S_RB_WAIT, S_RB_OUT};
   assign out_valid        = st == S_RB_OUT;

   strobe_timer #(.W(TW)) u_tmr (
      .clock   (clock),
      .rst_n   (rst_n),
      .load    (tmr_ld),
      .load_val(tmr_val),
      .done    (tmr_done)
   );

   always_comb begin
      nx      = st;
      tmr_ld  = 1'b0;
      tmr_val = TW'(SETUP_CYC);
      case (st)
         S_IDLE:
            if (in_valid) begin
               if (is_load(hdr_op)) nx = in_data[ADDR_W-1:0] == '0 ? S_LD_SEL : S_LD_WAIT;
               else if (hdr_op == OP_RUN) begin
                  nx      = S_RUN;
                  tmr_ld  = 1'b1;
                  tmr_val = TW'(RUN_CYCLES);
               end else if (hdr_op == OP_READBACK) nx = S_RB_ADDR;
            end
         S_LD_SEL: nx = S_IDLE;
         S_LD_WAIT:
            if (in_valid) begin
               nx     = S_LD_SETUP;
               tmr_ld = 1'b1;
            end
         S_LD_SETUP:
            if (tmr_done) begin
               nx      = S_LD_PULSE;
               tmr_ld  = 1'b1;
               tmr_val = TW'(PULSE_CYC);
            end
         S_LD_PULSE:
            if (tmr_done) begin
               nx      = S_LD_HOLD;
               tmr_ld  = 1'b1;
               tmr_val = TW'(HOLD_CYC);
            end
         S_LD_HOLD: if (tmr_done) nx = last ? S_IDLE : S_LD_WAIT;
         S_RUN: if (tmr_done) nx = S_IDLE;
         S_RB_ADDR:
            if (in_valid) begin
               nx     = cnt == '0 ? S_IDLE : S_RB_SETUP;
               tmr_ld = 1'b1;
            end
         S_RB_SETUP:
            if (tmr_done) begin
               nx      = S_RB_WAIT;
               tmr_ld  = 1'b1;
               tmr_val = TW'(RD_LAT_CYC);
            end
         S_RB_WAIT: if (tmr_done) nx = S_RB_OUT;
         S_RB_OUT:
            if (out_ready) begin
               nx      = S_RB_HOLD;
               tmr_ld  = 1'b1;
               tmr_val = TW'(HOLD_CYC);
            end
         S_RB_HOLD:
            if (tmr_done) begin
               nx     = last ? S_IDLE : S_RB_SETUP;
               tmr_ld = !last;
            end
         default: nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
         st           <= S_IDLE;
         op           <= '0;
         cnt          <= '0;
         addr_ext     <= '0;
         Data_in_ins  <= '0;
         Data_in_dram <= '0;
         out_data     <= '0;
         err          <= 1'b0;
      end else begin
         st <= nx;
         if (st == S_IDLE && hs) begin
            op  <= hdr_op;
            cnt <= in_data[ADDR_W-1:0];
            if (is_load(hdr_op)) addr_ext <= ADDR_W'(LOAD_BASE);
            if (hdr_op > OP_READBACK) err <= 1'b1;
         end
         if (st == S_LD_WAIT && hs) begin
            if (op == OP_LOAD_D) Data_in_dram <= in_data;
            else Data_in_ins <= in_data;
         end
         if (st == S_RB_ADDR && hs) addr_ext <= in_data[ADDR_W-1:0];
         if ((st == S_LD_HOLD || st == S_RB_HOLD) && tmr_done) begin
            addr_ext <= addr_ext + ADDR_W'(1);
            cnt      <= cnt - ADDR_W'(1);
         end
         if (st == S_RB_WAIT && tmr_done) out_data <= dram_in_1;
      end

`ifdef MEM_LOAD_CHECKSUM_EN
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) load_sum <= '0;
      else if (st == S_IDLE && hs && is_load(hdr_op)) load_sum <= '0;
      else if (st == S_LD_WAIT && hs) load_sum <= load_sum + in_data;
`endif
endmodule

// File: tb/tb_mem_load_sequencer.sv
// tb_mem_load_sequencer: randomized frame stimulus with a queue scoreboard for writes and readback words
module tb_mem_load_sequencer;
   logic        clock = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  addr_ext;
   logic [15:0] Data_in_ins, Data_in_dram, dram_in_1;
   logic        iram_write_ext_1, iram_write_ext_2, dram_write_ext, read_en_ext;
   logic        start, start_2, start_3, start_4, busy, err;
`ifdef MEM_LOAD_CHECKSUM_EN
   logic [15:0] load_sum;
`endif

   typedef struct {
      logic [1:0]  kind;
      logic [8:0]  addr;
      logic [15:0] data;
   } wr_t;
   wr_t         wq[$];
   logic [15:0] rq[$];
   logic [15:0] wbuf[16];
   int          n_vec = 0, n_mis = 0;
   int          rb_word = 0, stall_word = -1;

   always #5 clock = ~clock;
   assign dram_in_1 = 16'(addr_ext) + 16'd100;

   mem_load_sequencer #(.RUN_CYCLES(50)) dut (
      .clock(clock), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .addr_ext(addr_ext),
      .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram), .iram_write_ext_1(iram_write_ext_1),
      .iram_write_ext_2(iram_write_ext_2), .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext),
      .dram_in_1(dram_in_1), .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
      .busy(busy), .err(err)
`ifdef MEM_LOAD_CHECKSUM_EN
      , .load_sum(load_sum)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard monitor: pops expected writes on strobe rise and expected words on output handshakes
   logic [2:0]  stb, prev_stb = '0;
   logic [8:0]  paddr;
   logic [15:0] prev_od;
   logic        prev_ov = 1'b0, prev_or = 1'b0;
   int          plen = 0, cyc = 0, hs_cyc = 0;
   wr_t         e;
   always @(negedge clock) begin
      if (!rst_n) begin
         prev_stb = '0;
         prev_ov  = 1'b0;
         prev_or  = 1'b0;
      end else begin
         cyc++;
         stb = {iram_write_ext_1, iram_write_ext_2, dram_write_ext};
         if (stb != '0) begin
            check("strobe_onehot", 32'($onehot(stb)), 1);
            check("in_ready_in_strobe", in_ready, 0);
         end
         if (stb != '0 && prev_stb == '0) begin
            if (wq.size() == 0) check("unexpected_strobe", stb, 0);
            else begin
               e = wq.pop_front();
               check("strobe_kind", stb, 3'b100 >> e.kind);
               check("wr_addr", addr_ext, e.addr);
               check("wr_data", e.kind == 2'd2 ? Data_in_dram : Data_in_ins, e.data);
               check("mode_sel", {start_2, start_3, start_4, start}, e.kind == 2'd2 ? 4'b0100 : 4'b1000);
               check("strobe_latency", cyc - hs_cyc, 3);
            end
            plen  = 1;
            paddr = addr_ext;
         end else if (stb != '0) begin
            plen++;
            check("addr_stable_in_strobe", addr_ext, paddr);
         end
         if (stb == '0 && prev_stb != '0) check("pulse_len", plen, 4);
         if (in_valid && in_ready && (start_2 || start_3)) hs_cyc = cyc;
         if (prev_ov && !prev_or) begin
            check("rb_hold_valid", out_valid, 1);
            check("rb_hold_data", out_data, prev_od);
         end
         if (out_valid && out_ready) begin
            if (rq.size() == 0) check("unexpected_rb", out_data, 0);
            else check("rb_data", out_data, rq.pop_front());
         end
         prev_stb = stb;
         prev_ov  = out_valid;
         prev_or  = out_ready;
         prev_od  = out_data;
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (out_valid) begin
            repeat (rb_word == stall_word ? 4 : $urandom_range(0, 2)) begin
               @(posedge clock);
               #1;
            end
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
            rb_word++;
         end
      end
   end

   task automatic send(input logic [15:0] w, input int gap);
      int t = 0;
      repeat (gap) @(negedge clock);
      @(negedge clock);
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && t < 1000) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(t), 0);
         in_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clock);
      while (busy && t < 2000) begin
         @(negedge clock);
         t++;
      end
      check("idle", busy, 0);
      check("wq_drained", wq.size(), 0);
      check("rq_drained", rq.size(), 0);
      check("sel_idle", {start, start_2, start_3, start_4}, 0);
   endtask

   task automatic load_frame(input logic [2:0] op, input int cnt, input int gap);
      for (int i = 0; i < cnt; i++) wq.push_back('{kind: op[1:0], addr: 9'((1 + i) % 512), data: wbuf[i]});
      send({op, 4'($urandom), 9'(cnt)}, $urandom_range(0, 2));
      if (cnt == 0) begin
         @(negedge clock);
         check("sel_pulse", op == 3'd2 ? start_3 : start_2, 1);
         @(negedge clock);
         check("sel_drop", {start_2, start_3, busy}, 0);
      end
      for (int i = 0; i < cnt; i++) send(wbuf[i], i == 1 ? gap : $urandom_range(0, 2));
      wait_idle();
   endtask

   task automatic rb_frame(input int base, input int cnt, input int stall);
      rb_word    = 0;
      stall_word = stall;
      for (int i = 0; i < cnt; i++) rq.push_back(16'((base + i) % 512 + 100));
      send({3'd4, 4'($urandom), 9'(cnt)}, $urandom_range(0, 2));
      send({7'($urandom), 9'(base)}, $urandom_range(0, 2));
      wait_idle();
   endtask

   initial begin
      int n;
      logic bad;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clock);
      check("rst_ctrl", {start, start_2, start_3, start_4, iram_write_ext_1, iram_write_ext_2,
                         dram_write_ext, read_en_ext, out_valid, busy, err, in_ready}, 0);
      check("rst_addr", addr_ext, 0);
      check("rst_ins", Data_in_ins, 0);
      check("rst_dram", Data_in_dram, 0);
      check("rst_out", out_data, 0);
      #2 rst_n = 1'b1;

      wbuf[0] = 16'd11; wbuf[1] = 16'd22; wbuf[2] = 16'd33;
      load_frame(3'd0, 3, 0);
`ifdef MEM_LOAD_CHECKSUM_EN
      check("load_sum", load_sum, 66);
`endif

      wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
      load_frame(3'd2, 2, 5);

      send({3'd3, 13'($urandom)}, 0);
      n   = 0;
      bad = 1'b0;
      @(negedge clock);
      while (start && n < 200) begin
         n++;
         bad |= start_2 | start_3 | start_4;
         @(negedge clock);
      end
      check("run_len", n, 50);
      check("run_other_sel", bad, 0);
      check("run_busy_after", busy, 0);

      rb_frame(510, 3, 1);

      send({3'd7, 13'd3}, 0);
      @(negedge clock);
      check("bad_op_err", err, 1);
      check("bad_op_busy", busy, 0);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
      load_frame(3'd1, n, $urandom_range(0, 3));

      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) rb_frame($urandom_range(0, 511), n, -1);
         else begin
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            load_frame(3'($urandom_range(0, 2)), n, $urandom_range(0, 3));
         end
      end
      check("err_sticky", err, 1);

      wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
      for (int i = 0; i < 2; i++) wq.push_back('{kind: 2'd0, addr: 9'(1 + i), data: wbuf[i]});
      send({3'd0, 4'd0, 9'd2}, 0);
      send(wbuf[0], 0);
      n = 0;
      while (!iram_write_ext_1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("pulse_seen", iram_write_ext_1, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_strobe", iram_write_ext_1, 0);
      check("rst_async_sel", start_2, 0);
      check("rst_async_busy", busy, 0);
      check("rst_err_clear", err, 0);
      wq.delete();
      rq.delete();
      @(negedge clock);
      #2 rst_n = 1'b1;
      wbuf[0] = 16'($urandom);
      load_frame(3'd0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
